// File: rtl/neurosync_unidade_controle.sv
// neurosync_unidade_controle
// Control unit of the neurosync memory game. A Moore FSM sequences the
// datapath: it clears counters, latches the level, plays the LED sequence
// back, waits for each player move, checks it and stops on win, error or
// move timeout. The display/timeout timer lives here; memory, address and
// round counters and the comparator live in the datapath.
//
// Input protocol: jogar and confirma are levels sampled once per clock while
// the FSM is in a state that listens to them. jogada_feita is a one-cycle
// strobe qualified only in ESPERA_JOGADA; strobes arriving in any other
// state are dropped, so presses during playback never count as moves.
module neurosync_unidade_controle #(
    parameter int T_ON_FACIL   = 1000,
    parameter int T_ON_DIFICIL = 500,
    parameter int T_OFF        = 250,
    parameter int T_TIMEOUT    = 5000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       jogar,
    input  logic       confirma,
    input  logic       nivel,
    input  logic       jogada_feita,
    input  logic       jogada_correta,
    input  logic       fim_rodada,
    input  logic       fim_jogo,
    output logic       zera_contadores,
    output logic       zera_endereco,
    output logic       conta_endereco,
    output logic       conta_rodada,
    output logic       mostra_leds,
    output logic       nivel_reg,
    output logic       pronto,
    output logic       acertou,
    output logic       errou,
    output logic       timeout,
    output logic [3:0] db_estado
);

    // Timer is wide enough for the longest interval it ever has to measure.
    localparam int T_MAX = (T_ON_FACIL > T_TIMEOUT) ? T_ON_FACIL : T_TIMEOUT;
    localparam int TW    = $clog2(T_MAX + 1);

    // Terminal counts: the timer starts at 0 on entry, so an interval of N
    // cycles ends on the cycle where the timer reads N-1.
    localparam logic [TW-1:0] LIM_ON_FACIL   = TW'(T_ON_FACIL - 1);
    localparam logic [TW-1:0] LIM_ON_DIFICIL = TW'(T_ON_DIFICIL - 1);
    localparam logic [TW-1:0] LIM_OFF        = TW'(T_OFF - 1);
    localparam logic [TW-1:0] LIM_TIMEOUT    = TW'(T_TIMEOUT - 1);
    localparam logic [TW-1:0] TIMER_MAX      = '1;

    typedef enum logic [3:0] {
        INICIAL       = 4'd0,
        PREPARA       = 4'd1,
        ESPERA_NIVEL  = 4'd2,
        REGISTRA      = 4'd3,
        INICIO_RODADA = 4'd4,
        MOSTRA        = 4'd5,
        APAGA         = 4'd6,
        FIM_MOSTRA    = 4'd7,
        PROX_MOSTRA   = 4'd8,
        ESPERA_JOGADA = 4'd9,
        COMPARA       = 4'd10,
        PROX_JOGADA   = 4'd11,
        PROX_RODADA   = 4'd12,
        FIM_ACERTO    = 4'd13,
        FIM_ERRO      = 4'd14,
        FIM_TIMEOUT   = 4'd15
    } estado_t;

    estado_t       estado_q, estado_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          nivel_reg_q, nivel_reg_d;
    logic [TW-1:0] lim_on;
    logic          timed_state;

    // LED on-time follows the latched level, not the live switch.
    assign lim_on = nivel_reg_q ? LIM_ON_DIFICIL : LIM_ON_FACIL;

    // Only these three states measure time; every other state parks the
    // timer at zero so the next timed state always starts from a clean count.
    assign timed_state = (estado_q == MOSTRA) || (estado_q == APAGA) ||
                         (estado_q == ESPERA_JOGADA);

    // State, timer and level registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q    <= INICIAL;
            timer_q     <= '0;
            nivel_reg_q <= 1'b0;
        end else begin
            estado_q    <= estado_d;
            timer_q     <= timer_d;
            nivel_reg_q <= nivel_reg_d;
        end
    end

    // Next-state logic.
    always_comb begin
        estado_d = estado_q;
        case (estado_q)
            INICIAL:       if (jogar) estado_d = PREPARA;
            PREPARA:       estado_d = ESPERA_NIVEL;
            ESPERA_NIVEL:  if (confirma) estado_d = REGISTRA;
            REGISTRA:      estado_d = INICIO_RODADA;
            INICIO_RODADA: estado_d = MOSTRA;
            MOSTRA:        if (timer_q == lim_on) estado_d = APAGA;
            APAGA: begin
                if (timer_q == LIM_OFF) begin
                    estado_d = fim_rodada ? FIM_MOSTRA : PROX_MOSTRA;
                end
            end
            PROX_MOSTRA:   estado_d = MOSTRA;
            FIM_MOSTRA:    estado_d = ESPERA_JOGADA;
            ESPERA_JOGADA: begin
                // A press on the expiry cycle is still honoured.
                if (jogada_feita) begin
                    estado_d = COMPARA;
                end else if (timer_q == LIM_TIMEOUT) begin
                    estado_d = FIM_TIMEOUT;
                end
            end
            COMPARA: begin
                if (!jogada_correta) begin
                    estado_d = FIM_ERRO;
                end else if (fim_rodada && fim_jogo) begin
                    estado_d = FIM_ACERTO;
                end else if (fim_rodada) begin
                    estado_d = PROX_RODADA;
                end else begin
                    estado_d = PROX_JOGADA;
                end
            end
            PROX_JOGADA:   estado_d = ESPERA_JOGADA;
            PROX_RODADA:   estado_d = INICIO_RODADA;
            FIM_ACERTO,
            FIM_ERRO,
            FIM_TIMEOUT:   if (jogar) estado_d = PREPARA;
            default:       estado_d = INICIAL;
        endcase
    end

    // Timer: saturating count while staying in a timed state, zero otherwise.
    always_comb begin
        timer_d = '0;
        if (timed_state && (estado_d == estado_q)) begin
            timer_d = (timer_q == TIMER_MAX) ? timer_q : timer_q + 1'b1;
        end
    end

    // Level latch: captured only while passing through REGISTRA.
    always_comb begin
        nivel_reg_d = nivel_reg_q;
        if (estado_q == REGISTRA) begin
            nivel_reg_d = nivel;
        end
    end

    // Moore output decode from the current state.
    always_comb begin
        zera_contadores = 1'b0;
        zera_endereco   = 1'b0;
        conta_endereco  = 1'b0;
        conta_rodada    = 1'b0;
        mostra_leds     = 1'b0;
        pronto          = 1'b0;
        acertou         = 1'b0;
        errou           = 1'b0;
        timeout         = 1'b0;
        case (estado_q)
            PREPARA:       zera_contadores = 1'b1;
            INICIO_RODADA: zera_endereco   = 1'b1;
            MOSTRA:        mostra_leds     = 1'b1;
            FIM_MOSTRA:    zera_endereco   = 1'b1;
            PROX_MOSTRA:   conta_endereco  = 1'b1;
            PROX_JOGADA:   conta_endereco  = 1'b1;
            PROX_RODADA:   conta_rodada    = 1'b1;
            FIM_ACERTO: begin
                pronto  = 1'b1;
                acertou = 1'b1;
            end
            FIM_ERRO: begin
                pronto = 1'b1;
                errou  = 1'b1;
            end
            FIM_TIMEOUT: begin
                pronto  = 1'b1;
                timeout = 1'b1;
            end
            default: ;
        endcase
    end

    assign nivel_reg = nivel_reg_q;
    assign db_estado = estado_q;

endmodule
